// File: rtl/ff_pipe_bank.sv
// ff_pipe_bank: NCH independent valid/ready register pipelines of DEPTH stages
// with bubble collapsing, synchronous flush and registered per-channel occupancy.
module ff_pipe_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int NCH = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_srst,
    input  logic [NCH-1:0]       i_valid,
    output logic [NCH-1:0]       o_ready,
    input  logic [NCH*WIDTH-1:0] i_data,
    output logic [NCH-1:0]       o_valid,
    input  logic [NCH-1:0]       i_ready,
    output logic [NCH*WIDTH-1:0] o_data,
    output logic [NCH*CW-1:0]    o_count
);
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DEPTH-1:0] v;
        logic [WIDTH-1:0] d [DEPTH];
        logic [DEPTH-1:0] ld;
        logic [DEPTH-1:0] up_v;
        logic [WIDTH-1:0] up_d [DEPTH];
        logic [CW-1:0]    cnt;
        logic             acc;
        logic             dep;
        logic             r;
        // a stage loads when it or any stage downstream is empty, or the output drains
        always_comb begin
            r = i_ready[c];
            ld = '0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
                r = ~v[s] | r;
                ld[s] = r;
            end
        end
        always_comb begin
            up_v[0] = acc;
            up_d[0] = i_data[c*WIDTH +: WIDTH];
            for (int s = 1; s < DEPTH; s++) begin
                up_v[s] = v[s-1];
                up_d[s] = d[s-1];
            end
        end
        assign o_ready[c] = ld[0] & ~i_srst & i_arst;
        assign acc = i_valid[c] & o_ready[c];
        assign dep = v[DEPTH-1] & i_ready[c];
        assign o_valid[c] = v[DEPTH-1];
        assign o_data[c*WIDTH +: WIDTH] = d[DEPTH-1];
        assign o_count[c*CW +: CW] = cnt;
        always_ff @(posedge i_clk or negedge i_arst) begin
            if (!i_arst) begin
                v <= '0;
                d <= '{default: RST_VAL};
                cnt <= '0;
            end else if (i_srst) begin
                v <= '0;
                d <= '{default: RST_VAL};
                cnt <= '0;
            end else begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (ld[s]) begin
                        v[s] <= up_v[s];
                        if (up_v[s]) d[s] <= up_d[s];
                    end
                end
                cnt <= cnt + CW'(acc) - CW'(dep);
            end
        end
    end
endmodule

// File: doc/ff_pipe_bank.md
# ff_pipe_bank

Parametrised multi-channel elastic register pipeline. Each of `NCH` independent channels carries `WIDTH`-bit data through `DEPTH` valid/ready register stages. Features:
- synchronous flush
- bubble collapsing
- per-channel occupancy counters

It is the generalised successor of the fixed single-bit flop-style blocks (no-reset, sync-reset, async-reset). It is used wherever a variable-latency, back-pressurable register chain is needed between subsystems.

## Interface
Parameters:
- `WIDTH`, 8, data bits per channel (≥1)
- `DEPTH`, 3, register stages per channel (≥1)
- `NCH`, 2, number of independent channels (≥1)
- `RST_VAL`, 0, `WIDTH`-bit value loaded into every data register on reset or flush
- `CW`, `$clog2(DEPTH+1)`, derived occupancy-count width (localparam)

Ports:
- `i_clk`  in  1  single clock, all flops rising-edge
- `i_arst`  in  1  reset, asynchronous, active-low
- `i_srst`  in  1  synchronous flush, active-high
- `i_valid`  in  NCH  per-channel input valid
- `o_ready`  out  NCH  per-channel input ready
- `i_data`  in  NCH*WIDTH  input data, channel c at `[c*WIDTH +: WIDTH]`
- `o_valid`  out  NCH  per-channel output valid (last stage)
- `i_ready`  in  NCH  per-channel downstream ready
- `o_data`  out  NCH*WIDTH  output data, channel c at `[c*WIDTH +: WIDTH]`
- `o_count`  out  NCH*CW  per-channel registered occupancy, channel c at `[c*CW +: CW]`

## Operation
- **Per channel, stage s (0 = input, DEPTH-1 = output):**
  - holds register pair `v[s]` / `d[s]`.
  - `o_valid = v[DEPTH-1]` and `o_data = d[DEPTH-1]`.
- **Advance rule (combinational, right to left):**
  - `adv[DEPTH-1] = v[DEPTH-1] & i_ready`.
  - `load[s] = ~v[s] | adv[s]`, where `adv[s] = v[s] & load[s+1]`.
  - `o_ready = load[0] & ~i_srst & i_arst`.
- **Transfer:**
  - Input accepted when `i_valid & o_ready`.
  - Output departs when `o_valid & i_ready`.
  - Stage s with `load[s]=1` captures `v[s-1]` / `d[s-1]` (stage 0 captures the input).
- **Bubble collapse:** empty stages always load. A stalled output never blocks upstream items from filling empty stages.
- **Occupancy:**
  - `o_count` is a register updated each cycle with `+accept - depart`.
  - It always equals the number of set `v[s]` in that channel, range 0..DEPTH.
- **Data registers:** load only when `load[s]=1` and the upstream value is valid. They hold otherwise; no toggling on bubbles.
- **Flush (`i_srst=1` at an edge):**
  - All `v` cleared, all `d` set to `RST_VAL`, `o_count` set to 0, in all channels.
  - Input is dropped, since `o_ready=0` during flush.
  - `o_valid`/`o_data` before the flush edge are still a legal transfer if `i_ready=1`.
- **Async reset (`i_arst=0`):**
  - Immediately: `v=0`, `d=RST_VAL`, `o_count=0`, `o_ready=0`.
  - Applies mid-transfer without waiting for the clock.
- **Channel independence:** no signal of channel c affects channel k≠c, except the shared `i_srst`/`i_arst`.

## Timing
- **Reset values:**
  - `o_valid=0`, `o_data=RST_VAL`, `o_count=0`.
  - `o_ready=0` while `i_arst` is low.
  - `o_ready=1` in the first cycle after deassertion with `i_srst=0`.
- **Latency:** an item accepted at edge t with no stall is presented on `o_valid`/`o_data` after edge t+DEPTH-1. DEPTH=1 gives one register of latency.
- **Throughput:** one item per cycle per channel while `i_ready=1`.
- **Full pipeline (count=DEPTH) with `i_ready=1`:**
  - `o_ready=1`.
  - Simultaneous accept and depart; count unchanged.
- **Full pipeline with `i_ready=0`:** `o_ready=0`, all registers hold.
- **Combinational paths:** `o_ready` depends combinationally on `i_ready`, `i_srst` and `i_arst`. No combinational path from `i_valid` or `i_data` to any output.
- **Count arithmetic:** never wraps. Over- or underflow is impossible by construction; the bench asserts this.

## Test plan
- **Reset:**
  - Stimulus: hold `i_arst=0` for 3 cycles with random inputs.
  - Required: `o_valid=0`, `o_data=RST_VAL`, `o_count=0`, `o_ready=0` throughout.
  - After release: `o_ready=1`.
- **Streaming (WIDTH=8, DEPTH=3):**
  - Stimulus: ch0 sends 0x01..0x0A back-to-back with `i_ready=1`.
  - Required: 0x01 appears after the 3rd edge, then one item per cycle in order, `o_count` steady at 3.
- **Stall and collapse:**
  - Stimulus: `i_ready=0`, send 0xA1, 0xA2, 0xA3, 0xA4.
  - Required: 0xA1–0xA3 are accepted, `o_ready` drops after the 3rd accept, `o_count=3`.
  - Raise `i_ready`: 0xA4 is accepted in the same cycle 0xA1 departs.
- **Bubbles:**
  - Stimulus: send 0x11, idle 2 cycles, send 0x22 while `i_ready=0`.
  - Required: `o_count=2`; releasing `i_ready` outputs 0x11 then 0x22 on consecutive cycles.
- **Flush:**
  - Stimulus: with a full channel, assert `i_srst` for 1 cycle while `i_valid=1`, data 0x55.
  - Required: next cycle `o_valid=0`, `o_count=0`, `o_data=RST_VAL`; 0x55 is not accepted.
- **Channel isolation (NCH=2):**
  - Stimulus: ch1 stalled full while ch0 streams.
  - Required: ch0 output is unaffected; ch1 data holds its values bit-exact.
